spart_driver: RTL and testbench
===============================

# spart_driver

Bus master for the SPART that stands in for the processor side of the databus. After reset it programs the baud-rate divisor selected by the `br_cfg` switches. It then echoes every received character back out: wait for receive data, read it, wait for the transmit buffer, write it. It connects directly to the SPART's `iocs`/`iorw`/`ioaddr`/`databus`/`rda`/`tbr` pins and shares its clock.

## Interface
- `CLK_FREQ`, 50_000_000: system clock in Hz, used for divisor constants.
- `clk` input 1: system clock, all logic on rising edge.
- `rst` input 1: reset, asynchronous assert, active-low (0 = reset).
- `br_cfg` input 2: baud select from board switches, asynchronous. 00=4800, 01=9600, 10=19200, 11=38400.
- `rda` input 1: SPART receive data available.
- `tbr` input 1: SPART transmit buffer ready.
- `iocs` output 1: bus chip select, 1 for exactly the cycles of an access.
- `iorw` output 1: 1 = read, 0 = write.
- `ioaddr` output 2: 00 = TX/RX buffer, 01 = status, 10 = divisor low (DBL), 11 = divisor high (DBH).
- `databus` inout 8: driven only during write cycles (`iocs`=1, `iorw`=0), otherwise high-Z.

## Operation
- **br_cfg synchronizer.** `br_cfg` passes through a 2-flop synchronizer; FSM uses the synchronized value `cfg_s`.
- **Divisor.** DIV = CLK_FREQ/(16*baud) - 1, integer truncation, 16 bits. At 50 MHz: 4800 -> 0x028A, 9600 -> 0x0144, 19200 -> 0x00A1, 38400 -> 0x0050.
- **FSM states:**
  - INIT: 2 cycles for synchronizer fill, then WR_DBL.
  - WR_DBL: 1 cycle, `iocs`=1, `iorw`=0, `ioaddr`=10, bus = DIV[7:0]. Next: WR_DBH.
  - WR_DBH: same with `ioaddr`=11, bus = DIV[15:8]. Latches `cfg_s` into `cfg_ld`. Next: IDLE.
  - IDLE: `iocs`=0. Next is WR_DBL if reload pending (see Configuration), else RD_RX if `rda`=1, else stay.
  - RD_RX: 1 cycle, `iocs`=1, `iorw`=1, `ioaddr`=00. `databus` captured into 8-bit `rx_hold` on the closing edge. Next: WAIT_TBR.
  - WAIT_TBR: `iocs`=0. Next: WR_TX when `tbr`=1.
  - WR_TX: 1 cycle, `iocs`=1, `iorw`=0, `ioaddr`=00, bus = `rx_hold`. Next: IDLE.
- **No double read.** `rda` is sampled only in IDLE. The SPART must drop `rda` within 2 cycles of the read; the minimum path RD_RX -> WAIT_TBR -> WR_TX -> IDLE guarantees this.
- **Reset.** `rst` low at any time, including mid-access: `iocs`=0, `iorw`=1, `ioaddr`=00, `databus` high-Z, `rx_hold`=0x00, `cfg_ld`=00, synchronizer=00, state INIT. Any in-flight character is dropped.

## Timing
- Outputs are registered; never glitch during a cycle.
- Reset release at edge 0:
  - INIT occupies edges 0–1.
  - WR_DBL is visible from edge 2 to edge 3.
  - WR_DBH from edge 3 to edge 4.
  - IDLE from edge 4.
- Echo latency: `rda` high in IDLE -> RD_RX next cycle -> WR_TX at earliest 2 cycles after RD_RX (`tbr` already 1). Minimum 3 cycles from `rda` to the write strobe.
- Bus turnaround: `databus` is released in the same cycle `iocs` drops or `iorw` goes to 1. The driver never drives during RD_RX.
- `rda` and `tbr` high at once in IDLE: read first, as above. `tbr` is ignored outside WAIT_TBR.

## Configuration
- `SPART_DRV_RELOAD_EN` defined:
  - In IDLE, `cfg_s` != `cfg_ld` sets reload pending. The FSM goes to WR_DBL, taking priority over `rda`.
  - A change during an echo takes effect on the next IDLE, so no character is aborted.
- Not defined: divisor is programmed once after reset. `br_cfg` changes are ignored until the next reset, and IDLE only checks `rda`.

## Test plan
- **Reset programming.** Release reset with `br_cfg`=01, CLK_FREQ=50M -> exactly two write cycles: `ioaddr`=10 data 0x44, then `ioaddr`=11 data 0x01. Then idle, `iocs`=0.
- **All rates.** Repeat reset for `br_cfg`=00/10/11 -> DBL/DBH = 8A/02, A1/00, 50/00.
- **Single echo.** Model SPART returns 0x5A on the read and drops `rda` 1 cycle later; `tbr`=1 -> one read at `ioaddr`=00, then one write of 0x5A at `ioaddr`=00 three cycles after `rda` rose. `databus` is Z during the read.
- **Back-pressure.** Hold `tbr`=0 for 40 cycles after the read -> no write, `iocs`=0 throughout. Raise `tbr` -> write of the held byte on the following cycle.
- **Mid-access reset.** Assert `rst`=0 during WAIT_TBR holding 0xC3 -> outputs go to reset values immediately, no write occurs, and reprogramming follows release.
- **Reload.** With `SPART_DRV_RELOAD_EN`, switch `br_cfg` 01 -> 11 while idle -> within 4 cycles writes DBL 0x50, DBH 0x00. Without the macro -> no bus activity.

Source files
------------

// File: rtl/spart_driver.sv
`timescale 1ns/1ps
`default_nettype none
// spart_driver: SPART bus master that programs the baud divisor after reset, then echoes every received byte.
// Optional feature macro: SPART_DRV_RELOAD_EN reprograms the divisor whenever br_cfg changes while idle.
module spart_driver #(
  parameter int CLK_FREQ = 50_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] br_cfg,
  input  logic       rda,
  input  logic       tbr,
  output logic       iocs,
  output logic       iorw,
  output logic [1:0] ioaddr,
  inout  wire  [7:0] databus
);

  localparam logic [15:0] C_DIV_4800  = 16'(CLK_FREQ / (16 * 4800) - 1);
  localparam logic [15:0] C_DIV_9600  = 16'(CLK_FREQ / (16 * 9600) - 1);
  localparam logic [15:0] C_DIV_19200 = 16'(CLK_FREQ / (16 * 19200) - 1);
  localparam logic [15:0] C_DIV_38400 = 16'(CLK_FREQ / (16 * 38400) - 1);

  typedef enum logic [2:0] {
    S_INIT, S_WR_DBL, S_WR_DBH, S_IDLE, S_RD_RX, S_WAIT_TBR, S_WR_TX
  } state_t;

  state_t      r_state, w_state_nxt;
  logic [1:0]  r_cnt, w_cnt_nxt;
  logic [1:0]  r_sync1, r_cfg_s;
  logic [7:0]  r_rx_hold;
  logic        r_iocs, r_iorw, r_drive;
  logic [1:0]  r_ioaddr;
  logic [7:0]  r_dout;
  logic        w_iocs, w_iorw, w_drive;
  logic [1:0]  w_ioaddr;
  logic [7:0]  w_dout;
  logic [15:0] w_div;
  logic        w_reload;

  always_comb begin
    w_div = C_DIV_9600;
    case (r_cfg_s)
      2'b00:   w_div = C_DIV_4800;
      2'b01:   w_div = C_DIV_9600;
      2'b10:   w_div = C_DIV_19200;
      default: w_div = C_DIV_38400;
    endcase
  end

`ifdef SPART_DRV_RELOAD_EN
  logic [1:0] r_cfg_ld;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cfg_ld <= 2'b00;
    end else if (r_state == S_WR_DBH) begin
      r_cfg_ld <= r_cfg_s;
    end
  end

  assign w_reload = (r_cfg_s != r_cfg_ld);
`else
  assign w_reload = 1'b0;
`endif

  // Outputs are decoded from the next state and registered, so they change only on the clock edge.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      S_INIT: begin
        if (r_cnt == 2'd2) w_state_nxt = S_WR_DBL;
        else               w_cnt_nxt   = r_cnt + 2'd1;
      end
      S_WR_DBL:   w_state_nxt = S_WR_DBH;
      S_WR_DBH:   w_state_nxt = S_IDLE;
      S_IDLE: begin
        if (w_reload)  w_state_nxt = S_WR_DBL;
        else if (rda)  w_state_nxt = S_RD_RX;
      end
      S_RD_RX:    w_state_nxt = S_WAIT_TBR;
      S_WAIT_TBR: if (tbr) w_state_nxt = S_WR_TX;
      S_WR_TX:    w_state_nxt = S_IDLE;
      default:    w_state_nxt = S_INIT;
    endcase

    w_iocs   = 1'b0;
    w_iorw   = 1'b1;
    w_ioaddr = 2'b00;
    w_dout   = 8'h00;
    w_drive  = 1'b0;
    case (w_state_nxt)
      S_WR_DBL: begin
        w_iocs = 1'b1; w_iorw = 1'b0; w_ioaddr = 2'b10; w_dout = w_div[7:0]; w_drive = 1'b1;
      end
      S_WR_DBH: begin
        w_iocs = 1'b1; w_iorw = 1'b0; w_ioaddr = 2'b11; w_dout = w_div[15:8]; w_drive = 1'b1;
      end
      S_RD_RX: begin
        w_iocs = 1'b1;
      end
      S_WR_TX: begin
        w_iocs = 1'b1; w_iorw = 1'b0; w_dout = r_rx_hold; w_drive = 1'b1;
      end
      default: begin
        w_iocs = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= S_INIT;
      r_cnt     <= 2'd0;
      r_sync1   <= 2'b00;
      r_cfg_s   <= 2'b00;
      r_rx_hold <= 8'h00;
      r_iocs    <= 1'b0;
      r_iorw    <= 1'b1;
      r_ioaddr  <= 2'b00;
      r_dout    <= 8'h00;
      r_drive   <= 1'b0;
    end else begin
      r_sync1   <= br_cfg;
      r_cfg_s   <= r_sync1;
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_iocs    <= w_iocs;
      r_iorw    <= w_iorw;
      r_ioaddr  <= w_ioaddr;
      r_dout    <= w_dout;
      r_drive   <= w_drive;
      if (r_state == S_RD_RX) r_rx_hold <= databus;
    end
  end

  assign iocs    = r_iocs;
  assign iorw    = r_iorw;
  assign ioaddr  = r_ioaddr;
  assign databus = r_drive ? r_dout : 8'bz;

endmodule
`default_nettype wire

// File: tb/tb_spart_driver.sv
`timescale 1ns/1ps
`default_nettype none
// tb_spart_driver: models the SPART side of the bus; expected bus accesses (kind, address, data, cycle)
// are queued by the stimulus and popped by a monitor on every chip-select cycle.
module tb_spart_driver;
  localparam int CLK_FREQ = 50_000_000;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [1:0] br_cfg;
  logic       rda, tbr;
  logic       iocs, iorw;
  logic [1:0] ioaddr;
  wire  [7:0] databus;
  logic [7:0] rx_byte;

  int cyc    = 0;
  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic        rw;
    logic [1:0]  addr;
    logic [7:0]  data;
    logic [31:0] cyc;
  } acc_t;

  acc_t exp_q[$];
  acc_t m_got, m_exp;

  spart_driver #(.CLK_FREQ(CLK_FREQ)) dut (
    .clk(clk), .rst(rst), .br_cfg(br_cfg), .rda(rda), .tbr(tbr),
    .iocs(iocs), .iorw(iorw), .ioaddr(ioaddr), .databus(databus)
  );

  always #5 clk = ~clk;

  // SPART model: presents the received byte whenever the master reads the data register.
  assign databus = (iocs && iorw && ioaddr == 2'b00) ? rx_byte : 8'bz;

  always @(posedge clk or negedge rst) begin
    if (!rst) cyc <= 0;
    else      cyc <= cyc + 1;
  end

  function automatic logic [15:0] div_for(input logic [1:0] cfg);
    int baud;
    baud = 4800 << cfg;
    return 16'(CLK_FREQ / (16 * baud) - 1);
  endfunction

  function automatic void expect_acc(input logic rw, input logic [1:0] a, input logic [7:0] d, input int c);
    acc_t e;
    e.rw = rw; e.addr = a; e.data = d; e.cyc = c;
    exp_q.push_back(e);
  endfunction

  always @(negedge clk) begin
    if (rst && iocs) begin
      m_got.rw   = iorw;
      m_got.addr = ioaddr;
      m_got.data = iorw ? 8'h00 : databus;
      m_got.cyc  = cyc;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_access got rw=%0b addr=%0d data=%02h cyc=%0d, required no access",
                 m_got.rw, m_got.addr, m_got.data, m_got.cyc);
      end else begin
        m_exp = exp_q.pop_front();
        if (m_got != m_exp) begin
          errors++;
          $display("FAIL bus_access got rw=%0b addr=%0d data=%02h cyc=%0d, required rw=%0b addr=%0d data=%02h cyc=%0d",
                   m_got.rw, m_got.addr, m_got.data, m_got.cyc, m_exp.rw, m_exp.addr, m_exp.data, m_exp.cyc);
        end
      end
    end
  end

  task automatic wait_cyc(input int n);
    while (cyc < n) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic check_out(input string name);
    checks++;
    if ({iocs, iorw, ioaddr} !== 4'b0100) begin
      errors++;
      $display("FAIL %s got iocs=%b iorw=%b ioaddr=%b, required iocs=0 iorw=1 ioaddr=00", name, iocs, iorw, ioaddr);
    end
  endtask

  task automatic reset_release(input logic [1:0] cfg);
    logic [15:0] d;
    rst = 1'b0;
    br_cfg = cfg;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_out("in_reset");
    d = div_for(cfg);
    expect_acc(1'b0, 2'b10, d[7:0], 3);
    expect_acc(1'b0, 2'b11, d[15:8], 4);
    rst = 1'b1;
    wait_cyc(6);
  endtask

  task automatic echo(input logic [7:0] b, input int tdly);
    int c;
    rx_byte = b;
    tbr = (tdly == 0);
    rda = 1'b1;
    c = cyc;
    expect_acc(1'b1, 2'b00, 8'h00, c + 1);
    if (tdly == 0) expect_acc(1'b0, 2'b00, b, c + 3);
    wait_cyc(c + 2);
    rda = 1'b0;
    if (tdly > 0) begin
      wait_cyc(c + 1 + tdly);
      tbr = 1'b1;
      expect_acc(1'b0, 2'b00, b, c + 2 + tdly);
    end
    wait_cyc(c + 4 + tdly);
    tbr = 1'b0;
    wait_cyc(cyc + int'($urandom_range(0, 3)));
  endtask

  initial begin
    #200us;
    $display("FAIL watchdog timeout at cyc=%0d", cyc);
    $fatal(1);
  end

  initial begin
    logic [1:0] cfgs [5];
    int c;
    cfgs = '{2'b01, 2'b00, 2'b10, 2'b11, 2'b01};
    br_cfg = 2'b01; rda = 1'b0; tbr = 1'b0; rx_byte = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    check_out("reset_state");

    foreach (cfgs[i]) begin
      reset_release(cfgs[i]);
      wait_cyc(10);
    end

    echo(8'h5A, 0);
    for (int i = 0; i < 16; i++) echo(8'($urandom), int'($urandom_range(0, 5)));
    echo(8'($urandom), 41);

    // Reset while a byte is held waiting for the transmitter: the byte must be dropped.
    rx_byte = 8'hC3; tbr = 1'b0; rda = 1'b1; c = cyc;
    expect_acc(1'b1, 2'b00, 8'h00, c + 1);
    wait_cyc(c + 2);
    rda = 1'b0;
    wait_cyc(c + 3);
    rst = 1'b0;
    #1;
    check_out("mid_access_reset");
    tbr = 1'b1;
    reset_release(2'b01);
    wait_cyc(20);
    tbr = 1'b0;

    // Baud switch change while idle.
    c = cyc;
    br_cfg = 2'b11;
`ifdef SPART_DRV_RELOAD_EN
    begin
      logic [15:0] d;
      d = div_for(2'b11);
      expect_acc(1'b0, 2'b10, d[7:0], c + 3);
      expect_acc(1'b0, 2'b11, d[15:8], c + 4);
    end
`endif
    wait_cyc(c + 12);

    echo(8'hA5, 2);
    wait_cyc(cyc + 4);

    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL pending_accesses got %0d outstanding, required 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
